uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with oversampled bit recovery and a receive FIFO.

---
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a show-ahead receive FIFO.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   rd_en         pop the FIFO head this cycle (ignored when empty)
//   ready         FIFO non-empty
//   valid         1-cycle pulse: received frame written into the FIFO
//   data          FIFO head (show-ahead, stale when empty)
//   count         FIFO occupancy, 0..FIFO_DEPTH
//   framing_err   1-cycle pulse: stop bit sampled low, frame dropped
//   overrun       1-cycle pulse: good frame dropped because FIFO full
//   parity_err    1-cycle pulse with valid on parity mismatch
//
// Build option: define UART_RX_PARITY_EN to add a parity bit between the data
// bits and the stop bit (PARITY_ODD selects odd/even). Without it parity_err
// is tied low and PARITY_ODD has no effect.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic                          ready,
  output logic                          valid,
  output logic [DATA_BITS-1:0]          data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          framing_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BC_W  = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_fifo: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [1:0]            fill_q, fill_d;
  logic                  armed_q, armed_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  stop_ok, stop_bad, pop, push, full;

  // The synchroniser resets to 1, so its reset value must not arm the
  // receiver: fill_q marks when rx_s_q holds a genuinely sampled rx value.
  always_comb begin
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & rx_s_q);
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (armed_q && !rx_s_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          par_err_d = (rx_s_q != ((^shift_q) ^ PAR_SENSE));
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          stop_ok  = rx_s_q;
          stop_bad = !rx_s_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    full     = (count_q == DEPTH_C);
    pop      = rd_en && (count_q != '0);
    push     = stop_ok && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign ready       = (count_q != '0);
  assign valid       = push;
  assign data        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign framing_err = stop_bad;
  assign overrun     = stop_ok && full && !pop;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = stop_ok && par_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4).
// Stimulus queues expected events (valid/framing/overrun); the monitor pops
// them on every DUT event and keeps a reference FIFO to check popped data.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Cycles from the start-bit drive edge to the edge before the push cycle.
  localparam int PUSH_CYC = 154 + CPB * PAR_BITS;

  logic          clk = 1'b0;
  logic          rst, rx, rd_en;
  logic          ready, valid, framing_err, overrun, parity_err;
  logic [DB-1:0] data;
  logic [2:0]    count;

  int   total = 0;
  int   bad   = 0;
  logic flip_par = 1'b0;

  typedef struct {
    int          kind;   // 0 valid, 1 framing_err, 2 overrun
    logic [7:0]  d;
    logic        perr;
  } ev_t;
  ev_t        evq[$];
  logic [7:0] model[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH),
    .PARITY_ODD  (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .ready      (ready),
    .valid      (valid),
    .data       (data),
    .count      (count),
    .framing_err(framing_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop-before-push so a simultaneous pop/push frame checks the old head.
  always @(negedge clk) begin
    ev_t        e;
    int         act_kind;
    logic [7:0] x;
    if (!rst) begin
      if (rd_en && ready) begin
        total++;
        if (model.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected actual=0x%0h expected=<none>", data);
        end else begin
          x = model.pop_front();
          if (data !== x) begin
            bad++;
            $display("FAIL pop_data actual=0x%0h expected=0x%0h", data, x);
          end
        end
      end
      if (valid || framing_err || overrun || parity_err) begin
        act_kind = (int'(valid) + int'(framing_err) + int'(overrun) != 1) ? 7 :
                   valid ? 0 : framing_err ? 1 : 2;
        total++;
        if (evq.size() == 0) begin
          bad++;
          $display("FAIL event_unexpected actual_kind=%0d perr=%0b expected=<none>",
                   act_kind, parity_err);
        end else begin
          e = evq.pop_front();
          if (act_kind != e.kind || parity_err !== e.perr) begin
            bad++;
            $display("FAIL event actual_kind=%0d perr=%0b expected_kind=%0d perr=%0b byte=0x%0h",
                     act_kind, parity_err, e.kind, e.perr, e.d);
          end
          if (valid) model.push_back(e.d);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip_par);
`endif
    drive_bit(stop_b);
  endtask

  task automatic send_ok(input logic [7:0] d);
    evq.push_back('{0, d, flip_par});
    send(d, 1'b1);
  endtask

  task automatic send_bad_stop(input logic [7:0] d);
    evq.push_back('{1, d, 1'b0});
    send(d, 1'b0);
  endtask

  task automatic send_overrun(input logic [7:0] d);
    evq.push_back('{2, d, 1'b0});
    send(d, 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    bad++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_data", data, 0);
    idle(10);

    // 1: single frame then pop
    send_ok(8'hA5);
    idle(20);
    chk("t1_ready", ready, 1);
    chk("t1_count", count, 1);
    chk("t1_data", data, 'hA5);
    pop_one();
    chk("t1_ready_after_pop", ready, 0);
    chk("t1_count_after_pop", count, 0);

    // 2: overrun on fifth frame, FIFO order preserved
    for (int i = 1; i <= 4; i++) begin
      send_ok(8'(i));
      idle(4);
    end
    send_overrun(8'h05);
    idle(20);
    chk("t2_count_full", count, 4);
    chk("t2_head", data, 'h01);
    for (int i = 0; i < 4; i++) pop_one();
    chk("t2_count_empty", count, 0);
    chk("t2_model_empty", model.size(), 0);

    // 3: short low glitch is rejected, receiver still works afterwards
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle(40);
    chk("t3_no_event", evq.size(), 0);
    chk("t3_count", count, 0);
    send_ok(8'hC3);
    idle(20);
    chk("t3_next_frame", count, 1);
    pop_one();

    // 4: framing error drops the frame; next good frame accepted
    send_bad_stop(8'h3C);
    idle(30);
    chk("t4_count", count, 0);
    send_ok(8'h7E);
    idle(20);
    chk("t4_count_good", count, 1);
    chk("t4_data", data, 'h7E);
    pop_one();

    // 5: push into a full FIFO with a pop in the same cycle
    send_ok(8'h11); idle(4);
    send_ok(8'h22); idle(4);
    send_ok(8'h33); idle(4);
    send_ok(8'h44); idle(4);
    chk("t5_full", count, 4);
    fork
      send_ok(8'h55);
      begin
        repeat (PUSH_CYC) @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    idle(20);
    chk("t5_count_kept", count, 4);
    chk("t5_head", data, 'h22);
    for (int i = 0; i < 4; i++) pop_one();
    chk("t5_count_empty", count, 0);
    chk("t5_model_empty", model.size(), 0);

    // 6: reset mid-frame with rx held low across release
    send_ok(8'h66);
    idle(10);
    chk("t6_pre_count", count, 1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model.delete();
    evq.delete();
    rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_ready", ready, 0);
    chk("t6_valid", valid, 0);
    chk("t6_ferr", framing_err, 0);
    repeat (60) @(posedge clk);
    #1;
    chk("t6_no_event_low", evq.size(), 0);
    chk("t6_count_low", count, 0);
    idle(20);
    send_ok(8'h5A);
    idle(20);
    chk("t6_rearmed", count, 1);
    chk("t6_data", data, 'h5A);
    pop_one();

`ifdef UART_RX_PARITY_EN
    // 7: bad parity still pushes, parity_err with valid
    flip_par = 1'b1;
    send_ok(8'h0F);
    flip_par = 1'b0;
    idle(20);
    chk("t7_count", count, 1);
    chk("t7_data", data, 'h0F);
    pop_one();
`endif

    idle(10);
    chk("end_events_drained", evq.size(), 0);
    chk("end_model_drained", model.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
